// File: rtl/add_sub_scaled_pipe_pkg.sv
// Shared definitions for the scaled fixed-point {scale, mantissa} arithmetic units.
// Overflow-mode encodings and internal-width derivation reused by the add/sub, mul and div pipes.
package add_sub_scaled_pipe_pkg;

  localparam int DEF_MANT_W  = 13;
  localparam int DEF_SCALE_W = 3;

  typedef enum logic [1:0] {
    MODE_FLAG   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_RENORM = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Aligned-operand width: the largest scale difference shifts a mantissa left by 2^SCALE_W-1.
  function automatic int calc_iw(input int mant_w, input int scale_w);
    return mant_w + (1 << scale_w);
  endfunction

endpackage

// File: rtl/add_sub_scaled_pipe_if.sv
// Operand/result streaming bundle for add_sub_scaled_pipe.
interface add_sub_scaled_pipe_if
  import add_sub_scaled_pipe_pkg::*;
#(
  parameter int MANT_W  = DEF_MANT_W,
  parameter int SCALE_W = DEF_SCALE_W
);
  localparam int W = MANT_W + SCALE_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic         inexact;

  modport master (
    output in_valid, a, b, sub, cin, mode, out_ready,
    input  in_ready, out_valid, result, ovf, inexact
  );

  modport slave (
    input  in_valid, a, b, sub, cin, mode, out_ready,
    output in_ready, out_valid, result, ovf, inexact
  );

endinterface

// File: rtl/scaled_fx_renorm.sv
// Combinational renormaliser: finds the smallest right shift k <= rs that brings the wide sum
// into mantissa range, returning the reduced scale, shifted mantissa and discarded-bits flag.
module scaled_fx_renorm
  import add_sub_scaled_pipe_pkg::*;
#(
  parameter int MANT_W  = DEF_MANT_W,
  parameter int SCALE_W = DEF_SCALE_W
)(
  input  logic [calc_iw(MANT_W, SCALE_W):0] sum,
  input  logic [SCALE_W-1:0]                rs,
  output logic                              found,
  output logic [SCALE_W-1:0]                scale,
  output logic [MANT_W-1:0]                 mant,
  output logic                              inexact
);
  localparam int SW = calc_iw(MANT_W, SCALE_W) + 1;

  logic [SW-1:0]       shifted;
  logic [SW-MANT_W:0]  hi;

  // Equivalent to a leading-sign-bit count, clamped to the available scale.
  always_comb begin
    found   = 1'b0;
    scale   = '0;
    mant    = '0;
    inexact = 1'b0;
    shifted = '0;
    hi      = '0;
    for (int unsigned k = 0; k < (1 << SCALE_W); k++) begin
      shifted = $signed(sum) >>> k;
      hi      = shifted[SW-1:MANT_W-1];
      if (!found && (k <= 32'(rs)) && ((&hi) || !(|hi))) begin
        found   = 1'b1;
        scale   = rs - k[SCALE_W-1:0];
        mant    = shifted[MANT_W-1:0];
        inexact = |(sum & ~({SW{1'b1}} << k));
      end
    end
  end

endmodule

// File: rtl/add_sub_scaled_pipe.sv
// Three-stage add/subtract for {scale, mantissa} words: align, add, overflow handling.
// All stages advance together whenever the output register is empty or being drained.
module add_sub_scaled_pipe
  import add_sub_scaled_pipe_pkg::*;
#(
  parameter int MANT_W  = DEF_MANT_W,
  parameter int SCALE_W = DEF_SCALE_W
)(
  input logic                clk,
  input logic                rst_n,
  add_sub_scaled_pipe_if.slave bus
);
  localparam int W  = MANT_W + SCALE_W;
  localparam int IW = calc_iw(MANT_W, SCALE_W);
  localparam int SW = IW + 1;

  logic adv;

  // S1 registers: aligned operands
  logic                 s1_valid;
  logic [IW-1:0]        s1_a, s1_b;
  logic [SCALE_W-1:0]   s1_rs;
  logic                 s1_sub, s1_cin;
  mode_e                s1_mode;

  // S2 registers: wide sum
  logic                 s2_valid;
  logic [SW-1:0]        s2_sum;
  logic [SCALE_W-1:0]   s2_rs;
  mode_e                s2_mode;

  // S3 / output registers
  logic                 out_valid_q;
  logic [W-1:0]         result_q;
  logic                 ovf_q, inexact_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.inexact   = inexact_q;

  logic [SCALE_W-1:0] sa, sb, rs_c;
  logic [IW-1:0]      a_al, b_al;

  always_comb begin
    sa   = bus.a[W-1:MANT_W];
    sb   = bus.b[W-1:MANT_W];
    rs_c = (sa > sb) ? sa : sb;
    a_al = {{(IW-MANT_W){bus.a[MANT_W-1]}}, bus.a[MANT_W-1:0]} << (rs_c - sa);
    b_al = {{(IW-MANT_W){bus.b[MANT_W-1]}}, bus.b[MANT_W-1:0]} << (rs_c - sb);
  end

  logic [SW-1:0] a_x, b_x, sum_c;

  // Subtract as A + ~B + !cin, so cin acts as a borrow.
  always_comb begin
    a_x   = {s1_a[IW-1], s1_a};
    b_x   = {s1_b[IW-1], s1_b};
    sum_c = a_x + (s1_sub ? ~b_x : b_x) + SW'(s1_sub ^ s1_cin);
  end

  logic                fits;
  logic [SW-MANT_W:0]  sum_hi;
  logic [MANT_W-1:0]   sat_mant;
  logic                rn_found, rn_inexact;
  logic [SCALE_W-1:0]  rn_scale;
  logic [MANT_W-1:0]   rn_mant;
  logic [W-1:0]        nx_result;
  logic                nx_ovf, nx_inexact;

  scaled_fx_renorm #(.MANT_W(MANT_W), .SCALE_W(SCALE_W)) u_renorm (
    .sum     (s2_sum),
    .rs      (s2_rs),
    .found   (rn_found),
    .scale   (rn_scale),
    .mant    (rn_mant),
    .inexact (rn_inexact)
  );

  always_comb begin
    sum_hi     = s2_sum[SW-1:MANT_W-1];
    fits       = (&sum_hi) || !(|sum_hi);
    sat_mant   = s2_sum[SW-1] ? {1'b1, {(MANT_W-1){1'b0}}} : {1'b0, {(MANT_W-1){1'b1}}};
    nx_result  = {s2_rs, s2_sum[MANT_W-1:0]};
    nx_ovf     = 1'b0;
    nx_inexact = 1'b0;
    if (!fits) begin
      unique case (s2_mode)
        MODE_FLAG: nx_ovf = 1'b1;
        MODE_RENORM: begin
          if (rn_found) begin
            nx_result  = {rn_scale, rn_mant};
            nx_inexact = rn_inexact;
          end else begin
            nx_result = {{SCALE_W{1'b0}}, sat_mant};
            nx_ovf    = 1'b1;
          end
        end
        default: begin
          nx_result = {s2_rs, sat_mant};
          nx_ovf    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_rs       <= '0;
      s1_sub      <= 1'b0;
      s1_cin      <= 1'b0;
      s1_mode     <= MODE_FLAG;
      s2_valid    <= 1'b0;
      s2_sum      <= '0;
      s2_rs       <= '0;
      s2_mode     <= MODE_FLAG;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (bus.in_valid) begin
        s1_a    <= a_al;
        s1_b    <= b_al;
        s1_rs   <= rs_c;
        s1_sub  <= bus.sub;
        s1_cin  <= bus.cin;
        s1_mode <= mode_e'(bus.mode);
      end
      if (s1_valid) begin
        s2_sum  <= sum_c;
        s2_rs   <= s1_rs;
        s2_mode <= s1_mode;
      end
      if (s2_valid) begin
        result_q  <= nx_result;
        ovf_q     <= nx_ovf;
        inexact_q <= nx_inexact;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_scaled_pipe.sv
// Scoreboard bench for add_sub_scaled_pipe: directed beats push hand-computed results,
// a negedge monitor pops and compares each transferred output.
module tb_add_sub_scaled_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_sub_scaled_pipe_if #(.MANT_W(13), .SCALE_W(3)) bus ();

  add_sub_scaled_pipe #(.MANT_W(13), .SCALE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic        o;
    logic        i;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_id = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic cin, input logic [1:0] mode, input logic [15:0] er,
                      input logic eo, input logic ei, input logic expect_it);
    logic acc;
    int   g;
    acc = 1'b0;
    g   = 0;
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.mode = mode;
    bus.in_valid = 1'b1;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      g++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for beat a=%h b=%h", a, b);
    end else if (expect_it) begin
      exp_q.push_back('{r: er, o: eo, i: ei, id: next_id});
      next_id++;
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready hold at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got result=%h ovf=%b inexact=%b, want no beat",
                   bus.result, bus.ovf, bus.inexact);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d{result,ovf,inexact}", e.id),
                32'({bus.result, bus.ovf, bus.inexact}), 32'({e.r, e.o, e.i}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.mode = 2'd0; bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_inexact",   32'(bus.inexact),   32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Alignment, carry and borrow
    send(16'h4064, 16'h0003, 1'b0, 1'b0, 2'd0, 16'h4070, 1'b0, 1'b0, 1'b1);
    send(16'h4064, 16'h0003, 1'b0, 1'b1, 2'd0, 16'h4071, 1'b0, 1'b0, 1'b1);
    send(16'h4064, 16'h0003, 1'b1, 1'b1, 2'd0, 16'h4057, 1'b0, 1'b0, 1'b1);
    send(16'h0003, 16'h4064, 1'b1, 1'b0, 2'd0, 16'h5FA8, 1'b0, 1'b0, 1'b1);
    send(16'h4064, 16'h0003, 1'b0, 1'b0, 2'd2, 16'h4070, 1'b0, 1'b0, 1'b1);
    // Positive overflow in each mode
    send(16'h2FA0, 16'h2FA0, 1'b0, 1'b0, 2'd0, 16'h3F40, 1'b1, 1'b0, 1'b1);
    send(16'h2FA0, 16'h2FA0, 1'b0, 1'b0, 2'd1, 16'h2FFF, 1'b1, 1'b0, 1'b1);
    send(16'h2FA0, 16'h2FA0, 1'b0, 1'b0, 2'd2, 16'h0FA0, 1'b0, 1'b0, 1'b1);
    send(16'h2FA0, 16'h2FA0, 1'b0, 1'b0, 2'd3, 16'h2FFF, 1'b1, 1'b0, 1'b1);
    send(16'h2FA1, 16'h2FA0, 1'b0, 1'b0, 2'd2, 16'h0FA0, 1'b0, 1'b1, 1'b1);
    // Negative extremes
    send(16'h1000, 16'h1000, 1'b0, 1'b0, 2'd2, 16'h1000, 1'b1, 1'b0, 1'b1);
    send(16'h1000, 16'h1000, 1'b1, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h1000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h1000, 16'h1000, 1'b0, 1'b0, 2'd1, 16'h1000, 1'b1, 1'b0, 1'b1);
    send(16'h3001, 16'h3000, 1'b0, 1'b0, 2'd2, 16'h1000, 1'b0, 1'b1, 1'b1);
    // Renormalise limits: k beyond rs saturates, partial drop reports inexact
    send(16'hEFFF, 16'h0FFF, 1'b0, 1'b0, 2'd2, 16'h0FFF, 1'b1, 1'b0, 1'b1);
    send(16'hEFFF, 16'h0001, 1'b0, 1'b0, 2'd2, 16'hC83F, 1'b0, 1'b1, 1'b1);
    send(16'h0FFF, 16'h0000, 1'b0, 1'b0, 2'd1, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h0000, 1'b1, 1'b0, 2'd1, 16'h1000, 1'b0, 1'b0, 1'b1);
    drain("directed");

    // Back-pressure: 5 beats, output held off 6 cycles from first out_valid
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(16'(i + 1), 16'h0001, 1'b0, 1'b0, 2'd0, 16'(i + 2), 1'b0, 1'b0, 1'b1);
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("stall_first_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 6; c++) begin
          check($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
          check($sformatf("stall%0d_result", c), 32'(bus.result), 32'h0002);
          if (c < 5) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stream");

    // Reset with two beats in flight
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    send(16'h0002, 16'h0001, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result",    32'(bus.result),    32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_in_ready",  32'(bus.in_ready),  32'd1);
    send(16'h0005, 16'h0001, 1'b1, 1'b0, 2'd0, 16'h0004, 1'b0, 1'b0, 1'b1);
    drain("recovery");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
